// File: rtl/sram_ctrl_pkg.sv
// Shared sizing and FSM state encoding for the SRAM write-port scheduler.
package sram_ctrl_pkg;

  localparam int SETS   = 128;
  localparam int BANKS  = 8;
  localparam int DATA_W = 32;
  localparam int SET_W  = $clog2(SETS);
  localparam int BANK_W = $clog2(BANKS);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    REFILL = 2'd2
  } state_t;

endpackage

// File: rtl/sram_wport_mux.sv
// Registered write-port stage: places one word into its bank slot and builds the one-hot mask.
module sram_wport_mux
  import sram_ctrl_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue,
  input  logic                    sweep,
  input  logic [BANK_W-1:0]       slot,
  input  logic [SET_W-1:0]        set,
  input  logic [DATA_W-1:0]       word,
  output logic                    w_en,
  output logic [SET_W-1:0]        w_addr,
  output logic [BANKS*DATA_W-1:0] w_data,
  output logic [BANKS-1:0]        w_mask
);

  logic [BANKS*DATA_W-1:0] placed;

  // NOTE: a default on every comb output before the partial-select write keeps this latch-free.
  always_comb begin
    placed = '0;
    placed[slot*DATA_W +: DATA_W] = word;
  end

  // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_en   <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      w_mask <= '0;
    end else if (issue) begin
      w_en   <= 1'b1;
      w_addr <= set;
      w_mask <= sweep ? {BANKS{1'b1}} : (BANKS'(1) << slot);
      w_data <= sweep ? '0 : placed;
    end else begin
      // Address and data hold; only enable and mask are meaningful when idle.
      w_en   <= 1'b0;
      w_mask <= '0;
    end
  end

endmodule

// File: rtl/sram_wport_sched.sv
// Write-port owner: post-reset clear sweep, then refill-over-store arbitration with store slip.
module sram_wport_sched
  import sram_ctrl_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  output logic                    init_done,
  input  logic                    refill_req_valid,
  output logic                    refill_req_ready,
  input  logic [SET_W-1:0]        refill_req_set,
  input  logic                    refill_beat_valid,
  output logic                    refill_beat_ready,
  input  logic [DATA_W-1:0]       refill_beat_data,
  output logic                    refill_done,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [SET_W-1:0]        st_set,
  input  logic [BANK_W-1:0]       st_bank,
  input  logic [DATA_W-1:0]       st_data,
  input  logic [SET_W-1:0]        sram_r_addr,
  output logic                    sram_w_en,
  output logic [SET_W-1:0]        sram_w_addr,
  output logic [BANKS*DATA_W-1:0] sram_w_data,
  output logic [BANKS-1:0]        sram_w_maskOH,
  output logic                    rd_hazard
);

  state_t              state;
  logic [SET_W-1:0]    sweep_cnt;
  logic [BANK_W-1:0]   beat_cnt;
  logic [SET_W-1:0]    refill_set;

  logic                issue;
  logic                sweep;
  logic [BANK_W-1:0]   slot;
  logic [SET_W-1:0]    set;
  logic [DATA_W-1:0]   word;
  logic                rq_fire;
  logic                beat_fire;
  logic                st_fire;

  always_comb begin
    issue             = 1'b0;
    sweep             = 1'b0;
    slot              = '0;
    set               = '0;
    word              = '0;
    rq_fire           = 1'b0;
    beat_fire         = 1'b0;
    st_fire           = 1'b0;
    refill_req_ready  = 1'b0;
    refill_beat_ready = 1'b0;
    st_ready          = 1'b0;
    case (state)
      INIT: begin
        issue = 1'b1;
        sweep = 1'b1;
        set   = sweep_cnt;
      end
      IDLE: begin
        refill_req_ready = 1'b1;
        st_ready         = !refill_req_valid;
        rq_fire          = refill_req_valid;
        st_fire          = st_valid && st_ready;
      end
      REFILL: begin
        refill_beat_ready = 1'b1;
        // A store slips into beat gaps unless it targets the line being refilled.
        st_ready          = !refill_beat_valid && (st_set != refill_set);
        beat_fire         = refill_beat_valid;
        st_fire           = st_valid && st_ready;
      end
      default: ;
    endcase
    if (beat_fire) begin
      issue = 1'b1;
      slot  = beat_cnt;
      set   = refill_set;
      word  = refill_beat_data;
    end else if (st_fire) begin
      issue = 1'b1;
      slot  = st_bank;
      set   = st_set;
      word  = st_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      sweep_cnt   <= '0;
      beat_cnt    <= '0;
      refill_set  <= '0;
      init_done   <= 1'b0;
      refill_done <= 1'b0;
    end else begin
      refill_done <= beat_fire && (beat_cnt == BANK_W'(BANKS-1));
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == SET_W'(SETS-1)) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (rq_fire) begin
            state      <= REFILL;
            refill_set <= refill_req_set;
            beat_cnt   <= '0;
          end
        end
        REFILL: begin
          if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == BANK_W'(BANKS-1)) state <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  sram_wport_mux u_mux (
    .clock  (clock),
    .reset  (reset),
    .issue  (issue),
    .sweep  (sweep),
    .slot   (slot),
    .set    (set),
    .word   (word),
    .w_en   (sram_w_en),
    .w_addr (sram_w_addr),
    .w_data (sram_w_data),
    .w_mask (sram_w_maskOH)
  );

  assign rd_hazard = sram_w_en && (sram_r_addr == sram_w_addr);

endmodule

// File: tb/tb_sram_wport_sched.sv
// Randomised and directed bench for sram_wport_sched against a transaction-level model.
module tb_sram_wport_sched;
  import sram_ctrl_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    init_done;
  logic                    refill_req_valid = 1'b0;
  logic                    refill_req_ready;
  logic [SET_W-1:0]        refill_req_set = '0;
  logic                    refill_beat_valid = 1'b0;
  logic                    refill_beat_ready;
  logic [DATA_W-1:0]       refill_beat_data = '0;
  logic                    refill_done;
  logic                    st_valid = 1'b0;
  logic                    st_ready;
  logic [SET_W-1:0]        st_set = '0;
  logic [BANK_W-1:0]       st_bank = '0;
  logic [DATA_W-1:0]       st_data = '0;
  logic [SET_W-1:0]        sram_r_addr = '0;
  logic                    sram_w_en;
  logic [SET_W-1:0]        sram_w_addr;
  logic [BANKS*DATA_W-1:0] sram_w_data;
  logic [BANKS-1:0]        sram_w_maskOH;
  logic                    rd_hazard;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which phase we are in, how far the sweep got, and the refill line in progress.
  bit       m_init;
  bit       m_init_done;
  int       m_sweep;
  bit       m_refill;
  int       m_set;
  int       m_beats;
  int       m_done_pulses;

  sram_wport_sched dut (
    .clock             (clock),
    .reset             (reset),
    .init_done         (init_done),
    .refill_req_valid  (refill_req_valid),
    .refill_req_ready  (refill_req_ready),
    .refill_req_set    (refill_req_set),
    .refill_beat_valid (refill_beat_valid),
    .refill_beat_ready (refill_beat_ready),
    .refill_beat_data  (refill_beat_data),
    .refill_done       (refill_done),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_set            (st_set),
    .st_bank           (st_bank),
    .st_data           (st_data),
    .sram_r_addr       (sram_r_addr),
    .sram_w_en         (sram_w_en),
    .sram_w_addr       (sram_w_addr),
    .sram_w_data       (sram_w_data),
    .sram_w_maskOH     (sram_w_maskOH),
    .rd_hazard         (rd_hazard)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] place(input int s, input logic [31:0] w);
    logic [255:0] v;
    v = '0;
    v[s*32 +: 32] = w;
    return v;
  endfunction

  task automatic model_reset();
    m_init      = 1'b1;
    m_init_done = 1'b0;
    m_sweep     = 0;
    m_refill    = 1'b0;
    m_set       = 0;
    m_beats     = 0;
  endtask

  // Entered just after a rising edge; drives one cycle of inputs and checks both
  // the combinational handshakes and the write registered at the next edge.
  task automatic step(input bit rqv, input int rqs, input bit btv, input logic [31:0] btd,
                      input bit stv, input int sts, input int stb, input logic [31:0] std,
                      input int ra);
    bit           e_rq_rdy, e_bt_rdy, e_st_rdy, e_en, e_done;
    int           e_addr;
    logic [7:0]   e_mask;
    logic [255:0] e_data;
    refill_req_valid  = rqv;
    refill_req_set    = SET_W'(rqs);
    refill_beat_valid = btv;
    refill_beat_data  = btd;
    st_valid          = stv;
    st_set            = SET_W'(sts);
    st_bank           = BANK_W'(stb);
    st_data           = std;
    sram_r_addr       = SET_W'(ra);
    #1;
    e_rq_rdy = !m_init && !m_refill;
    e_bt_rdy = m_refill;
    e_st_rdy = m_init ? 1'b0 : (m_refill ? (!btv && sts != m_set) : !rqv);
    check("refill_req_ready", 256'(refill_req_ready), 256'(e_rq_rdy));
    check("refill_beat_ready", 256'(refill_beat_ready), 256'(e_bt_rdy));
    check("st_ready", 256'(st_ready), 256'(e_st_rdy));

    e_en = 1'b0; e_done = 1'b0; e_addr = 0; e_mask = '0; e_data = '0;
    if (m_init) begin
      e_en = 1'b1; e_addr = m_sweep; e_mask = 8'hFF;
      m_sweep++;
      if (m_sweep == SETS) begin m_init = 1'b0; m_init_done = 1'b1; end
    end else if (m_refill && btv) begin
      e_en = 1'b1; e_addr = m_set; e_mask = 8'(1 << m_beats); e_data = place(m_beats, btd);
      if (m_beats == BANKS-1) begin e_done = 1'b1; m_refill = 1'b0; m_done_pulses++; end
      m_beats++;
    end else if (!m_refill && rqv) begin
      m_refill = 1'b1; m_set = rqs; m_beats = 0;
    end else if (stv && e_st_rdy) begin
      e_en = 1'b1; e_addr = sts; e_mask = 8'(1 << stb); e_data = place(stb, std);
    end

    @(posedge clock); #1;
    check("sram_w_en", 256'(sram_w_en), 256'(e_en));
    check("sram_w_maskOH", 256'(sram_w_maskOH), 256'(e_mask));
    if (e_en) begin
      check("sram_w_addr", 256'(sram_w_addr), 256'(e_addr));
      check("sram_w_data", sram_w_data, e_data);
    end
    check("refill_done", 256'(refill_done), 256'(e_done));
    check("init_done", 256'(init_done), 256'(m_init_done));
    check("rd_hazard", 256'(rd_hazard), 256'(e_en && ra == e_addr));
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_w_en", 256'(sram_w_en), 256'(0));
    check("rst_w_addr", 256'(sram_w_addr), 256'(0));
    check("rst_w_data", sram_w_data, 256'(0));
    check("rst_w_mask", 256'(sram_w_maskOH), 256'(0));
    check("rst_refill_done", 256'(refill_done), 256'(0));
    check("rst_init_done", 256'(init_done), 256'(0));
    check("rst_readies", 256'({refill_req_ready, refill_beat_ready, st_ready}), 256'(0));
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    m_done_pulses = 0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Sweep with junk requests that must all be ignored.
    for (int i = 0; i < SETS; i++)
      step(1, 3, 1, $urandom, 1, 4, 2, $urandom, i);
    check("sweep_last_addr", 256'(sram_w_addr), 256'(SETS-1));
    check("sweep_init_done", 256'(init_done), 256'(1));
    idle_step();

    // Back-to-back refill of set 0x15.
    step(1, 'h15, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < BANKS; k++)
      step(0, 0, 1, 32'hA0 + k, 0, 0, 0, 0, 0);
    check("refill_last_mask", 256'(sram_w_maskOH), 256'(8'h80));
    check("refill_last_slot", 256'(sram_w_data[7*32 +: 32]), 256'(32'hA7));
    check("refill_done_pulse", 256'(refill_done), 256'(1));
    idle_step();

    // Simultaneous refill and store; the store slips into the first beat-free cycle.
    step(1, 'h15, 0, 0, 1, 'h30, 5, 32'h1234_5678, 0);
    step(0, 0, 0, 0, 1, 'h30, 5, 32'h1234_5678, 0);
    check("slip_first_addr", 256'(sram_w_addr), 256'('h30));
    for (int k = 0; k < BANKS; k++)
      step(0, 0, 1, $urandom, 0, 0, 0, 0, 0);

    // Same-set store held off; other-set store slips into a gap.
    step(1, 'h15, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 'h15, 1, 32'hBEEF, 0);
    for (int k = 0; k < 3; k++)
      step(0, 0, 1, $urandom, 1, 'h15, 1, 32'hBEEF, 0);
    step(0, 0, 0, 0, 1, 'h20, 3, 32'hDEAD, 0);
    check("gap_store_addr", 256'(sram_w_addr), 256'('h20));
    check("gap_store_mask", 256'(sram_w_maskOH), 256'(8'h08));
    check("gap_store_slot3", 256'(sram_w_data[3*32 +: 32]), 256'(32'hDEAD));
    for (int k = 3; k < BANKS; k++)
      step(0, 0, 1, $urandom, 1, 'h15, 1, 32'hBEEF, 0);
    step(0, 0, 0, 0, 1, 'h15, 1, 32'hBEEF, 0);
    check("held_store_addr", 256'(sram_w_addr), 256'('h15));

    // Read/write collision flag.
    step(0, 0, 0, 0, 1, 'h07, 2, 32'h77, 'h07);
    check("hazard_same_set", 256'(rd_hazard), 256'(1));
    step(0, 0, 0, 0, 1, 'h07, 2, 32'h77, 'h08);
    check("hazard_other_set", 256'(rd_hazard), 256'(0));

    // Reset in the middle of a refill, after beat 4.
    m_done_pulses = 0;
    step(1, 'h40, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      step(0, 0, 1, $urandom, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 1, $urandom, 1, 2, 2, 32'h5, 0);
    check("sweep_restart_addr", 256'(sram_w_addr), 256'(0));
    check("no_done_after_reset", 256'(m_done_pulses), 256'(0));
    for (int i = 1; i < SETS; i++)
      step(0, 0, 1, $urandom, 0, 0, 0, 0, 0);

    // Random traffic over a few sets so collisions and slips are frequent.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 7), $urandom,
           $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
